cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 Parameters: none; the block fixes 2 ways, 1 LRU bit per set, and 1-cycle array read latency.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_read  in  1  CPU read request, held until mem_resp.
REQ-005 mem_write  in  1  CPU write request, held until mem_resp.
REQ-006 mem_resp  out  1  one-cycle completion pulse to CPU.
REQ-007 hit  in  2  per-way valid&tag-match, meaningful the cycle after array_read.
REQ-008 lru  in  1  way index of the LRU way (victim), same timing as hit.
REQ-009 victim_dirty  in  1  dirty bit of the way selected by lru, same timing as hit.
REQ-010 array_read  out  1  read strobe to tag/valid/dirty/LRU/data arrays.
REQ-011 tag_load, valid_load, dirty_load, data_we  out  2 each  per-way write enables.
REQ-012 dirty_in  out  1  value written on dirty_load.
REQ-013 lru_load  out  1, lru_in  out  1  LRU write enable and value.
REQ-014 data_src  out  1  0 = CPU write data, 1 = pmem line.
REQ-015 addr_sel  out  1  0 = CPU address, 1 = victim writeback address.
REQ-016 pmem_read, pmem_write  out  1 each  memory requests, held until pmem_resp; pmem_resp  in  1  memory completion.

Function
REQ-017 The FSM SHALL have states IDLE, LOOKUP, WRITEBACK, FILL, REREAD.
REQ-018 IDLE: on mem_read|mem_write, assert array_read, go LOOKUP; otherwise stay, all outputs 0.
REQ-019 LOOKUP hit (any hit bit): assert mem_resp, lru_load=1, lru_in = index of the way not hit, go IDLE.
REQ-020 LOOKUP write hit: additionally assert data_we and dirty_load on the hit way, dirty_in=1, data_src=0.
REQ-021 Both hit bits set: treat as a hit on way 0.
REQ-022 LOOKUP miss: latch victim = lru; go WRITEBACK if victim_dirty, else FILL; no mem_resp.
REQ-023 WRITEBACK: pmem_write=1, addr_sel=1; on pmem_resp go FILL.
REQ-024 FILL: pmem_read=1, addr_sel=0; on pmem_resp, in that cycle assert data_we, tag_load, valid_load, and dirty_load on the victim, with dirty_in=0 and data_src=1; go REREAD.
REQ-025 REREAD: assert array_read, go LOOKUP; the second lookup SHALL hit and complete per REQ-019/020.
REQ-026 Latency SHALL be: hit = 2 cycles from request to mem_resp; clean miss = 4 cycles + pmem latency; dirty miss = 5 cycles + two pmem latencies.
REQ-027 mem_read and mem_write both high SHALL be treated as a write.
REQ-028 pmem_resp outside WRITEBACK/FILL SHALL be ignored.
REQ-029 pmem_read and pmem_write SHALL never be asserted in the same cycle.
REQ-030 The victim latch SHALL stay constant from LOOKUP miss until REREAD.

Reset
REQ-031 rst SHALL force IDLE and clear victim on the next edge, from any state, including mid-WRITEBACK or mid-FILL.
REQ-032 While in reset and in the cycle after it, all outputs SHALL be 0.

Structure
REQ-033 The state enum and the data_src/addr_sel encodings SHALL live in the shared cache types package.
REQ-034 The block SHALL be a single module: a registered state and victim, plus a combinational output/next-state decoder; no sub-module.

Verification
REQ-035 Read hit: mem_read=1, hit=2'b01 in LOOKUP -> mem_resp in cycle 2, lru_load=1, lru_in=1, no pmem activity.
REQ-036 Write hit way 1: mem_write=1, hit=2'b10 -> data_we=2'b10, dirty_load=2'b10, dirty_in=1, lru_in=0, mem_resp cycle 2.
REQ-037 Clean miss: hit=0, lru=1, victim_dirty=0, pmem_resp after 3 cycles -> FILL writes way 1 (tag/valid/data_we=2'b10, data_src=1), REREAD, then hit -> mem_resp.
REQ-038 Dirty miss: lru=0, victim_dirty=1 -> pmem_write with addr_sel=1 until pmem_resp, then pmem_read, then fill way 0; pmem_read/pmem_write never overlap.
REQ-039 Reset in FILL: rst asserted while pmem_read=1 -> next cycle IDLE, all outputs 0; a new read then proceeds normally.
REQ-040 Spurious pmem_resp in IDLE and both-hit 2'b11 -> no state change, and way 0 is treated as the hit.

Source files
------------

// File: rtl/cache_control_pkg.sv
// Shared types for the two-way cache controller: FSM state encoding,
// datapath mux select encodings and a way-index to write-enable helper.
package cache_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_REREAD    = 3'd4
    } cache_state_e;

    // Data array write source select.
    typedef enum logic {
        DATA_SRC_CPU  = 1'b0,
        DATA_SRC_PMEM = 1'b1
    } data_src_e;

    // Memory address select.
    typedef enum logic {
        ADDR_SEL_CPU    = 1'b0,
        ADDR_SEL_VICTIM = 1'b1
    } addr_sel_e;

    // One-hot per-way enable for a way index.
    function automatic logic [1:0] way_mask(input logic way_idx);
        logic [1:0] mask_v;
        if (way_idx == 1'b1) begin
            mask_v = 2'b10;
        end else begin
            mask_v = 2'b01;
        end
        return mask_v;
    endfunction

endpackage

// File: rtl/cache_control.sv
// Two-way set-associative cache controller FSM: hit handling, victim
// writeback, line fill and re-lookup. Outputs are decoded combinationally
// from the registered state and victim so a hit completes in the cycle its
// tag compare result arrives.
module cache_control
    import cache_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    input  logic [1:0] hit,
    input  logic       lru,
    input  logic       victim_dirty,
    output logic       array_read,
    output logic [1:0] tag_load,
    output logic [1:0] valid_load,
    output logic [1:0] dirty_load,
    output logic [1:0] data_we,
    output logic       dirty_in,
    output logic       lru_load,
    output logic       lru_in,
    output logic       data_src,
    output logic       addr_sel,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp
);

    cache_state_e state_r;
    cache_state_e state_next_s;
    logic         victim_r;
    logic         victim_next_s;
    logic         rst_d_r;
    logic         hit_way_s;
    logic         quiet_s;

    // Both ways hitting resolves to way 0.
    assign hit_way_s = (hit[0] == 1'b1) ? 1'b0 : 1'b1;

    // Outputs stay low during reset and for one cycle after it.
    assign quiet_s = rst | rst_d_r;

    // State, victim latch and reset-delay flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            victim_r <= 1'b0;
            rst_d_r  <= 1'b1;
        end else begin
            state_r  <= state_next_s;
            victim_r <= victim_next_s;
            rst_d_r  <= 1'b0;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next_s  = state_r;
        victim_next_s = victim_r;
        mem_resp      = 1'b0;
        array_read    = 1'b0;
        tag_load      = 2'b00;
        valid_load    = 2'b00;
        dirty_load    = 2'b00;
        data_we       = 2'b00;
        dirty_in      = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        data_src      = DATA_SRC_CPU;
        addr_sel      = ADDR_SEL_CPU;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;

        if (quiet_s) begin
            state_next_s  = ST_IDLE;
            victim_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_read | mem_write) begin
                        array_read   = 1'b1;
                        state_next_s = ST_LOOKUP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end

                ST_LOOKUP: begin
                    if (hit != 2'b00) begin
                        mem_resp = 1'b1;
                        lru_load = 1'b1;
                        lru_in   = ~hit_way_s;
                        // A simultaneous read+write request is a write.
                        if (mem_write) begin
                            data_we    = way_mask(hit_way_s);
                            dirty_load = way_mask(hit_way_s);
                            dirty_in   = 1'b1;
                            data_src   = DATA_SRC_CPU;
                        end else begin
                            data_we    = 2'b00;
                        end
                        state_next_s = ST_IDLE;
                    end else begin
                        victim_next_s = lru;
                        if (victim_dirty) begin
                            state_next_s = ST_WRITEBACK;
                        end else begin
                            state_next_s = ST_FILL;
                        end
                    end
                end

                ST_WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = ADDR_SEL_VICTIM;
                    if (pmem_resp) begin
                        state_next_s = ST_FILL;
                    end else begin
                        state_next_s = ST_WRITEBACK;
                    end
                end

                ST_FILL: begin
                    pmem_read = 1'b1;
                    addr_sel  = ADDR_SEL_CPU;
                    if (pmem_resp) begin
                        data_we      = way_mask(victim_r);
                        tag_load     = way_mask(victim_r);
                        valid_load   = way_mask(victim_r);
                        dirty_load   = way_mask(victim_r);
                        dirty_in     = 1'b0;
                        data_src     = DATA_SRC_PMEM;
                        state_next_s = ST_REREAD;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end

                ST_REREAD: begin
                    array_read   = 1'b1;
                    state_next_s = ST_LOOKUP;
                end

                default: begin
                    state_next_s  = ST_IDLE;
                    victim_next_s = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Directed testbench for cache_control: each cycle the full output bundle is
// compared against a hand-computed vector on the falling clock edge.
module tb_cache_control;

    logic       clk;
    logic       rst;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic [1:0] hit;
    logic       lru;
    logic       victim_dirty;
    logic       array_read;
    logic [1:0] tag_load;
    logic [1:0] valid_load;
    logic [1:0] dirty_load;
    logic [1:0] data_we;
    logic       dirty_in;
    logic       lru_load;
    logic       lru_in;
    logic       data_src;
    logic       addr_sel;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;

    int n_cmp;
    int n_fail;

    logic [16:0] obs;

    cache_control dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_resp     (mem_resp),
        .hit          (hit),
        .lru          (lru),
        .victim_dirty (victim_dirty),
        .array_read   (array_read),
        .tag_load     (tag_load),
        .valid_load   (valid_load),
        .dirty_load   (dirty_load),
        .data_we      (data_we),
        .dirty_in     (dirty_in),
        .lru_load     (lru_load),
        .lru_in       (lru_in),
        .data_src     (data_src),
        .addr_sel     (addr_sel),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {mem_resp, array_read, tag_load, valid_load, dirty_load, data_we,
                  dirty_in, lru_load, lru_in, data_src, addr_sel, pmem_read, pmem_write};

    // Expected output bundle, same field order as obs.
    function automatic logic [16:0] ev(
        input logic resp, input logic ar,
        input logic [1:0] tl, input logic [1:0] vl, input logic [1:0] dl, input logic [1:0] dwe,
        input logic din, input logic lld, input logic lin, input logic dsrc, input logic asel,
        input logic pr, input logic pw);
        return {resp, ar, tl, vl, dl, dwe, din, lld, lin, dsrc, asel, pr, pw};
    endfunction

    // Check the current cycle at the falling edge, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [16:0] exp_v);
        @(negedge clk);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [16:0] ZERO = 17'h00000;

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        hit          = 2'b00;
        lru          = 1'b0;
        victim_dirty = 1'b0;
        pmem_resp    = 1'b0;
        #1;

        // Reset: outputs quiet during reset and one cycle after, even with a request held.
        cyc("rst_hold0", ZERO);
        cyc("rst_hold1", ZERO);
        rst = 1'b0;
        cyc("post_rst", ZERO);

        // Read hit on way 0.
        cyc("rdhit_idle", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        hit = 2'b01;
        cyc("rdhit_lookup", ev(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0));
        mem_read = 1'b0; hit = 2'b00;
        cyc("idle_quiet", ZERO);

        // Write hit on way 1.
        mem_write = 1'b1;
        cyc("wrhit_idle", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        hit = 2'b10;
        cyc("wrhit_lookup", ev(1'b1,1'b0,2'b00,2'b00,2'b10,2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));
        mem_write = 1'b0; hit = 2'b00;
        cyc("idle_after_wr", ZERO);

        // Clean miss, victim way 1; lru changes afterwards to prove the victim is latched.
        mem_read = 1'b1;
        cyc("cm_idle", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        lru = 1'b1; victim_dirty = 1'b0;
        cyc("cm_lookup_miss", ZERO);
        lru = 1'b0;
        cyc("cm_fill1", ev(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0));
        cyc("cm_fill2", ev(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0));
        pmem_resp = 1'b1;
        cyc("cm_fill_resp", ev(1'b0,1'b0,2'b10,2'b10,2'b10,2'b10,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0));
        pmem_resp = 1'b0;
        cyc("cm_reread", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        hit = 2'b10;
        cyc("cm_lookup_hit", ev(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));
        mem_read = 1'b0; hit = 2'b00;
        cyc("cm_idle_end", ZERO);

        // Dirty miss, victim way 0: writeback then fill, never overlapping.
        mem_read = 1'b1;
        cyc("dm_idle", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        lru = 1'b0; victim_dirty = 1'b1;
        cyc("dm_lookup_miss", ZERO);
        lru = 1'b1; victim_dirty = 1'b0;
        cyc("dm_wb1", ev(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1));
        cyc("dm_wb2", ev(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1));
        pmem_resp = 1'b1;
        cyc("dm_wb_resp", ev(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1));
        pmem_resp = 1'b0;
        cyc("dm_fill1", ev(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0));
        pmem_resp = 1'b1;
        cyc("dm_fill_resp", ev(1'b0,1'b0,2'b01,2'b01,2'b01,2'b01,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0));
        pmem_resp = 1'b0;
        cyc("dm_reread", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        hit = 2'b01;
        cyc("dm_lookup_hit", ev(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0));
        mem_read = 1'b0; hit = 2'b00;
        cyc("dm_idle_end", ZERO);

        // Reset in the middle of FILL.
        mem_read = 1'b1;
        cyc("rf_idle", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        lru = 1'b1; victim_dirty = 1'b0;
        cyc("rf_lookup_miss", ZERO);
        cyc("rf_fill", ev(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0));
        rst = 1'b1; pmem_resp = 1'b1;
        cyc("rf_in_reset", ZERO);
        rst = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0;
        cyc("rf_after_reset", ZERO);

        // Spurious pmem_resp in IDLE changes nothing.
        pmem_resp = 1'b1;
        cyc("spur_idle1", ZERO);
        pmem_resp = 1'b0;
        cyc("spur_idle2", ZERO);

        // New read proceeds normally after the reset.
        mem_read = 1'b1;
        cyc("rf_new_idle", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        hit = 2'b01;
        cyc("rf_new_hit", ev(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0));
        mem_read = 1'b0; hit = 2'b00;
        cyc("rf_new_idle_end", ZERO);

        // Read+write together with both ways hitting: a write hit on way 0.
        mem_read = 1'b1; mem_write = 1'b1;
        cyc("bh_idle", ev(1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        hit = 2'b11;
        cyc("bh_lookup", ev(1'b1,1'b0,2'b00,2'b00,2'b01,2'b01,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0));
        mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
        cyc("bh_idle_end", ZERO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
